eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single RGMII transmit byte path (8-bit data plus a contiguous-frame enable feeding the preamble-inserting RGMII sender) between NUM_REQ frame sources, e.g. UDP data, ARP, ICMP and DHCP.
- Grants round-robin, one frame at a time.
- Registers the granted source's byte stream onto the sender inputs.
- Holds off the next grant until the sender's active flag clears, so preamble purge and inter-frame gap always complete.
- Guards against stuck or runaway sources.

Parameters:
- NUM_REQ, 4, number of frame sources (2..8).
- MAX_LEN, 1518, maximum bytes per frame excluding preamble; longer frames are truncated.
- START_TIMEOUT, 16, cycles a granted source may take to raise its enable before the grant is withdrawn.

Ports:
- clock  in  1  byte clock, shared with the RGMII sender.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-source frame request; level, held until the frame ends.
- src_en  in  NUM_REQ  per-source byte-valid; must be contiguous for one frame.
- src_data  in  8*NUM_REQ  per-source byte; source i occupies bits [8i+7:8i].
- grant  out  NUM_REQ  one-hot grant, or zero.
- sender_active  in  1  active flag from the RGMII sender (high during frame, purge and gap).
- data  out  8  byte to the sender.
- tx_enable  out  1  frame enable to the sender.
- busy  out  1  high in any state other than IDLE.
- trunc_err  out  1  one-cycle pulse when a frame is cut at MAX_LEN.
- timeout_err  out  1  one-cycle pulse when a grant is withdrawn by timeout.

Behaviour:
- Reset (asynchronous, reset_n low):
  - grant, data, tx_enable, busy, trunc_err and timeout_err all 0.
  - state IDLE; RR pointer set so source 0 has highest priority; counters 0.
  - Reset mid-frame drops tx_enable immediately; the sender then purges and runs its gap on its own.
- States: IDLE, GRANT, SEND, DRAIN, WAIT_GAP.
- IDLE:
  - When any req is high and sender_active=0, grant the first requesting source searching upward (with wrap) from last_granted+1.
  - Go to GRANT, clear the timeout counter, set grant one-hot on the next edge.
  - While sender_active=1, no grant is issued.
- GRANT:
  - If src_en[g]=1 → SEND; this byte is the first captured byte, and the byte counter is set to 1.
  - Else if req[g]=0 → source aborted: drop grant, go to IDLE, no error.
  - Else if the counter reaches START_TIMEOUT-1 → pulse timeout_err, drop grant, go to IDLE.
  - The RR pointer updates to g whenever the grant is dropped.
- SEND:
  - Each cycle: data<=src_data[g], tx_enable<=src_en[g]. This gives exactly 1 cycle of latency.
  - src_en[g] falling ends the frame: tx_enable<=0, grant<=0 → WAIT_GAP.
  - If the byte counter reaches MAX_LEN while src_en[g] is still high: tx_enable<=0, pulse trunc_err, keep grant → DRAIN.
  - Byte counter is 11 bits and saturates.
- DRAIN:
  - tx_enable held 0; source bytes are discarded.
  - When src_en[g]=0 and req[g]=0, drop grant → WAIT_GAP.
- WAIT_GAP:
  - Minimum 2 cycles in this state; sender_active is ignored in the first cycle.
  - Then go to IDLE once sender_active=0.
- Inputs from non-granted sources (req, src_en, src_data) never affect data or tx_enable.
- grant is never more than one-hot. grant rises only from IDLE with sender_active=0.
- src_en[g] dropping for one cycle mid-frame ends the frame. Sources must not gap within a frame.
- Round robin: after source g is served, g has lowest priority on the next arbitration. If g is the only requester, it is re-granted after WAIT_GAP.
- Simultaneous req rise on several sources: only the winner is granted; the losers stay pending with no lost requests.

Test Plan:
- Single frame: source 1 sends 64 bytes 0x00..0x3F → grant=4'b0010 one cycle after req; data/tx_enable replicate the stream delayed 1 cycle, exactly 64 enabled cycles; no second grant until sender_active falls.
- Round robin: all 4 sources request continuously, 60-byte frames → grant order 0,1,2,3,0,1; every inter-frame interval spans the full sender_active tail.
- Truncation: MAX_LEN=100, source 2 sends 150 bytes → tx_enable high 100 cycles; trunc_err one pulse; grant held until source 2 drops en and req; remaining 50 bytes never appear on data.
- Timeout: source 3 raises req but never src_en → timeout_err pulses 16 cycles after grant; grant cleared; source 0 request pending at the same time is served next.
- Abort and interference: source 0 granted, drops req before en → back to IDLE, no error. Meanwhile a non-granted source toggles src_en and src_data → data/tx_enable stay 0.
- Reset mid-frame: assert reset_n low at byte 30 → tx_enable, grant and busy go 0 asynchronously. After release, source 0 has priority and the next frame starts cleanly once sender_active=0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin sharing of the RGMII transmit byte path between frame sources
module eth_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MAX_LEN = 1518,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   src_en,
   input  logic [8*NUM_REQ-1:0] src_data,
   output logic [NUM_REQ-1:0]   grant,
   input  logic                 sender_active,
   output logic [7:0]           data,
   output logic                 tx_enable,
   output logic                 busy,
   output logic                 trunc_err,
   output logic                 timeout_err
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam logic [2:0] IDLE = 3'd0, GRANT = 3'd1, SEND = 3'd2, DRAIN = 3'd3, WAIT_GAP = 3'd4;
   logic [2:0] state;
   logic [IW-1:0] idx, last, win;
   logic found;
   logic [TW-1:0] tcnt;
   logic [10:0] bcnt;
   logic gap_first;
   logic g_en, g_req;
   logic [7:0] g_data;
   always_comb begin
      g_en = src_en[idx];
      g_req = req[idx];
      g_data = src_data[{idx, 3'b000} +: 8];
   end
   always_comb begin
      win = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c;
         c = (int'(last) + k) % NUM_REQ;
         if (!found && req[c]) begin
            win = IW'(c);
            found = 1'b1;
         end
      end
   end
   assign busy = state != IDLE;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         grant <= '0;
         idx <= '0;
         last <= IW'(NUM_REQ - 1);
         tcnt <= '0;
         bcnt <= '0;
         gap_first <= 1'b0;
         data <= '0;
         tx_enable <= 1'b0;
         trunc_err <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         trunc_err <= 1'b0;
         timeout_err <= 1'b0;
         data <= '0;
         tx_enable <= 1'b0;
         case (state)
            IDLE: if (found && !sender_active) begin
               state <= GRANT;
               idx <= win;
               grant <= NUM_REQ'(1) << win;
               tcnt <= '0;
            end
            GRANT: if (g_en) begin
               state <= SEND;
               data <= g_data;
               tx_enable <= 1'b1;
               bcnt <= 11'd1;
            end else if (!g_req || tcnt == TW'(START_TIMEOUT - 1)) begin
               // a dropped request is a clean abort; only a live request times out
               timeout_err <= g_req;
               grant <= '0;
               last <= idx;
               state <= IDLE;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
            SEND: if (!g_en) begin
               grant <= '0;
               last <= idx;
               gap_first <= 1'b1;
               state <= WAIT_GAP;
            end else if (bcnt == 11'(MAX_LEN)) begin
               trunc_err <= 1'b1;
               state <= DRAIN;
            end else begin
               data <= g_data;
               tx_enable <= 1'b1;
               bcnt <= bcnt + {10'd0, ~&bcnt};
            end
            DRAIN: if (!g_en && !g_req) begin
               grant <= '0;
               last <= idx;
               gap_first <= 1'b1;
               state <= WAIT_GAP;
            end
            WAIT_GAP: begin
               // the sender may not yet have raised active on the first gap cycle
               gap_first <= 1'b0;
               if (!gap_first && !sender_active) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: randomized scoreboard bench for eth_tx_arbiter
module tb_eth_tx_arbiter;
   localparam int N = 4;
   localparam int ML = 100;
   localparam int ST = 16;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic kill = 1'b0;
   wire [N-1:0] req, src_en, src_idle;
   wire [8*N-1:0] src_data;
   logic [N-1:0] grant;
   logic sender_active = 1'b0;
   logic [7:0] data;
   logic tx_enable, busy, trunc_err, timeout_err;
   int checks = 0;
   int passes = 0;
   int mon_nbytes = 0;
   typedef struct {int mode; int len; int seed; int pre; int d;} job_t;
   job_t jobs[N][$];
   int exp_kind[N][$];
   int exp_len[N][$];
   logic [7:0] exp_byte[N][$];

   eth_tx_arbiter #(.NUM_REQ(N), .MAX_LEN(ML), .START_TIMEOUT(ST)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .src_en(src_en), .src_data(src_data),
      .grant(grant), .sender_active(sender_active), .data(data), .tx_enable(tx_enable),
      .busy(busy), .trunc_err(trunc_err), .timeout_err(timeout_err));

   always #5 clock = ~clock;

   function void chk_eq(string name, int act, int expv);
      checks++;
      if (act == expv) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
   endfunction

   function automatic int rr_pick(logic [N-1:0] r, int lst);
      for (int k = 1; k <= N; k++) if (r[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction

   function automatic int idx_of(logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return 0;
   endfunction

   // modes: 0 frame, 1 request without enable, 2 abort before enable, 3 rogue enable toggling without request
   task automatic push_job(int s, int mode, int len, int seed, int pre, int d);
      job_t j;
      int n;
      j.mode = mode; j.len = len; j.seed = seed; j.pre = pre; j.d = d;
      jobs[s].push_back(j);
      if (mode == 0) begin
         n = len > ML ? ML : len;
         for (int i = 0; i < n; i++) exp_byte[s].push_back(8'(seed + i));
         exp_len[s].push_back(n);
         exp_kind[s].push_back(len > ML ? 1 : 0);
      end else if (mode != 3) begin
         exp_kind[s].push_back(mode == 1 ? 2 : 3);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < N; s++) begin
         jobs[s].delete(); exp_kind[s].delete(); exp_len[s].delete(); exp_byte[s].delete();
      end
   endtask

   task automatic wait_quiet(int budget);
      int n;
      bit q;
      n = 0;
      do begin
         @(posedge clock); #2;
         n++;
         q = &src_idle && !busy && !sender_active && !tx_enable;
         for (int s = 0; s < N; s++) if (jobs[s].size() != 0) q = 0;
      end while (!q && n < budget);
      chk_eq("quiet_reached", int'(q), 1);
      repeat (2) @(negedge clock);
      for (int s = 0; s < N; s++) chk_eq("expect_left", exp_kind[s].size() + exp_byte[s].size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clock); #2;
      reset_n = 1'b0; kill = 1'b1;
      repeat (3) @(posedge clock);
      #2 clear_model();
      kill = 1'b0; reset_n = 1'b1;
   endtask

   // RGMII sender stand-in: active during the frame plus a random purge/gap tail
   initial begin
      int tail;
      tail = 0;
      forever begin
         @(posedge clock); #1;
         if (tx_enable) begin
            sender_active = 1'b1;
            tail = $urandom_range(1, 16);
         end else if (tail > 0) begin
            tail--;
            sender_active = tail != 0;
         end
      end
   end

   for (genvar s = 0; s < N; s++) begin : g_src
      logic rq = 1'b0;
      logic en = 1'b0;
      logic [7:0] bt = 8'h00;
      int st = 0;
      int cnt = 0;
      job_t j;
      assign req[s] = rq;
      assign src_en[s] = en;
      assign src_data[8*s +: 8] = bt;
      assign src_idle[s] = st == 0;
      initial forever begin
         @(posedge clock); #1;
         if (kill) begin
            rq = 0; en = 0; bt = 0; st = 0;
         end else begin
            if (st == 0 && jobs[s].size() != 0) begin
               j = jobs[s].pop_front(); cnt = j.pre; st = 1;
            end
            if (st == 1) begin
               if (cnt > 0) cnt--;
               else if (j.mode == 3) begin cnt = j.len; st = 6; end
               else begin rq = 1; st = 2; end
            end
            if (st == 2 && grant[s]) begin cnt = j.d; st = j.mode == 1 ? 5 : 3; end
            if (st == 3) begin
               if (cnt > 0) cnt--;
               else if (j.mode == 2) begin rq = 0; st = 8; end
               else begin cnt = 0; st = 4; end
            end
            if (st == 4) begin
               if (cnt < j.len) begin en = 1; bt = 8'(j.seed + cnt); cnt++; end
               else begin en = 0; bt = 0; rq = 0; st = 8; end
            end
            if (st == 5 && !grant[s]) begin rq = 0; st = 8; end
            if (st == 6) begin
               if (cnt > 0) begin en = 1'($urandom); bt = 8'($urandom); cnt--; end
               else begin en = 0; bt = 0; st = 8; end
            end
            if (st == 8) st = 0;
         end
      end
   end

   // monitor: arbitration, byte stream, error pulses and frame outcomes
   initial begin
      logic [N-1:0] p_req, p_grant;
      logic p_sa, p_busy;
      int last, cur, nb, gc, t, fall_t, kind, expv, eb;
      bit s_tr, s_to, gap_need;
      last = N - 1; p_req = 0; p_grant = 0; p_sa = 0; p_busy = 0;
      cur = 0; nb = 0; gc = 0; t = 0; fall_t = -100; s_tr = 0; s_to = 0; gap_need = 0;
      forever begin
         @(negedge clock);
         t++;
         if (!reset_n) begin
            last = N - 1; p_req = 0; p_grant = 0; p_sa = sender_active; p_busy = 0;
            nb = 0; gap_need = 0;
         end else begin
            if (p_grant != 0) gc++;
            chk_eq("grant_onehot", int'($onehot0(grant)), 1);
            if (!p_busy && p_grant == 0) begin
               expv = (p_req != 0 && !p_sa) ? (1 << rr_pick(p_req, last)) : 0;
               chk_eq("grant_arb", int'(grant), expv);
               if (grant != 0) begin
                  if (gap_need) chk_eq("gap_cycles", (t - fall_t) < 3 ? t - fall_t : 3, 3);
                  cur = idx_of(grant); nb = 0; gc = 0; s_tr = 0; s_to = 0;
               end
            end else begin
               chk_eq("grant_hold", int'(grant != 0 && grant != p_grant), 0);
            end
            if (!busy) chk_eq("idle_out", int'({tx_enable, data}), 0);
            if (tx_enable) begin
               eb = (grant != 0 && exp_byte[cur].size() != 0) ? int'(exp_byte[cur].pop_front()) : -1;
               chk_eq("tx_byte", int'(data), eb);
               nb++;
            end
            if (trunc_err) begin
               chk_eq("trunc_at", nb, ML);
               chk_eq("trunc_once", int'(s_tr), 0);
               chk_eq("trunc_grant_held", int'(grant != 0 && grant == p_grant), 1);
               s_tr = 1;
            end
            if (timeout_err) begin
               chk_eq("timeout_cycles", gc, ST);
               chk_eq("timeout_bytes", nb, 0);
               s_to = 1;
            end
            if (p_grant != 0 && grant == 0) begin
               kind = s_to ? 2 : s_tr ? 1 : nb > 0 ? 0 : 3;
               chk_eq("frame_kind", kind, exp_kind[cur].size() != 0 ? exp_kind[cur].pop_front() : -1);
               if (kind < 2) chk_eq("frame_len", nb, exp_len[cur].size() != 0 ? exp_len[cur].pop_front() : -1);
               gap_need = kind < 2;
               fall_t = t;
               last = cur;
            end
            p_req = req; p_grant = grant; p_sa = sender_active; p_busy = busy;
         end
         mon_nbytes = nb;
      end
   end

   initial begin
      int n;
      repeat (3) @(posedge clock);
      #1;
      chk_eq("rst_grant", int'(grant), 0);
      chk_eq("rst_data", int'(data), 0);
      chk_eq("rst_tx_enable", int'(tx_enable), 0);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_trunc_err", int'(trunc_err), 0);
      chk_eq("rst_timeout_err", int'(timeout_err), 0);
      @(posedge clock); #2 reset_n = 1'b1;
      push_job(1, 0, 64, 0, 0, 0);
      wait_quiet(3000);
      do_reset();
      for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) push_job(s, 0, 60, int'($urandom), 0, 0);
      wait_quiet(5000);
      push_job(2, 0, 150, 8'h40, 0, 1);
      wait_quiet(3000);
      push_job(3, 1, 1, 0, 0, 0);
      push_job(0, 0, 20, int'($urandom), 2, 0);
      wait_quiet(3000);
      push_job(2, 3, 40, 0, 0, 0);
      push_job(0, 2, 1, 0, 3, 5);
      wait_quiet(3000);
      push_job(0, 0, 80, int'($urandom), 0, 0);
      n = 0;
      while (mon_nbytes < 30 && n < 2000) begin @(posedge clock); n++; end
      chk_eq("reach_byte30", int'(mon_nbytes >= 30), 1);
      #3 reset_n = 1'b0;
      kill = 1'b1;
      #1;
      chk_eq("async_tx_enable", int'(tx_enable), 0);
      chk_eq("async_grant", int'(grant), 0);
      chk_eq("async_busy", int'(busy), 0);
      repeat (3) @(posedge clock);
      #2 clear_model();
      kill = 1'b0; reset_n = 1'b1;
      push_job(3, 0, 30, int'($urandom), 0, 0);
      push_job(0, 0, 30, int'($urandom), 0, 0);
      wait_quiet(3000);
      for (int r = 0; r < 5; r++) begin
         for (int s = 0; s < N; s++) begin
            int m, pre, d, seed;
            m = $urandom_range(0, 9); pre = $urandom_range(0, 20); d = $urandom_range(0, 8);
            seed = int'($urandom);
            if (m <= 5) push_job(s, 0, $urandom_range(1, 90), seed, pre, d);
            else if (m == 6) push_job(s, 0, $urandom_range(101, 130), seed, pre, d);
            else if (m == 7) push_job(s, 1, 1, seed, pre, d);
            else if (m == 8) push_job(s, 2, 1, seed, pre, d);
            else push_job(s, 3, $urandom_range(5, 30), seed, pre, d);
         end
      end
      wait_quiet(40000);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
